// File: rtl/power_threshold_detect_if.sv
// Settings bus, power stream and detector outputs for power_threshold_detect.
// master drives settings and samples; slave is the detector.
interface power_threshold_detect_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] power_in;
    logic        strobe_in;
    logic        trigger_out;
    logic        active;
    logic [31:0] peak_out;
    logic        peak_strobe;
    logic [15:0] event_count;

    modport master (
        output set_stb, set_addr, set_data, power_in, strobe_in,
        input  trigger_out, active, peak_out, peak_strobe, event_count
    );

    modport slave (
        input  set_stb, set_addr, set_data, power_in, strobe_in,
        output trigger_out, active, peak_out, peak_strobe, event_count
    );
endinterface

// File: rtl/power_threshold_detect.sv
// Hysteresis threshold detector with dwell qualifier and holdoff on an integrated-power stream.
// Optional event counter built when POWER_THRESH_EVENT_COUNT_EN is defined.
module power_threshold_detect #(
    parameter logic [7:0] SR_THRESH_HI = 8'd0,
    parameter logic [7:0] SR_THRESH_LO = 8'd1,
    parameter logic [7:0] SR_CTRL      = 8'd2,
    parameter logic [7:0] SR_HOLDOFF   = 8'd3
) (
    input  logic                     clk,
    input  logic                     reset,
    power_threshold_detect_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BELOW,
        S_ARMING,
        S_ACTIVE,
        S_HOLDOFF
    } state_t;

    logic [31:0] r_thresh_hi;
    logic [31:0] r_thresh_lo;
    logic        r_enable;
    logic [7:0]  r_dwell;
    logic [15:0] r_holdoff;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_dwell_cnt;
    logic [7:0]  w_dwell_cnt_next;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_cnt_next;
    logic [31:0] r_peak;
    logic [31:0] w_peak_next;
    logic [31:0] r_peak_out;
    logic [31:0] w_peak_out_next;
    logic        r_trigger;
    logic        w_trigger_next;
    logic        r_peak_stb;
    logic        w_peak_stb_next;

    logic        w_wr_ctrl;
    logic        w_enable_next;
    logic [31:0] w_lo_eff;
    logic        w_above;
    logic        w_below;
    logic [7:0]  w_dwell_eff;
    logic [8:0]  w_dwell_inc;
    logic        w_dwell_done;
    logic [31:0] w_peak_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_thresh_hi <= 32'd0;
            r_thresh_lo <= 32'd0;
            r_enable    <= 1'b0;
            r_dwell     <= 8'd0;
            r_holdoff   <= 16'd0;
        end else if (bus.set_stb) begin
            case (bus.set_addr)
                SR_THRESH_HI: r_thresh_hi <= bus.set_data;
                SR_THRESH_LO: r_thresh_lo <= bus.set_data;
                SR_CTRL: begin
                    r_enable <= bus.set_data[0];
                    r_dwell  <= bus.set_data[15:8];
                end
                SR_HOLDOFF:   r_holdoff <= bus.set_data[15:0];
                default: ;
            endcase
        end
    end

    // A pending enable write is seen by the FSM at the same edge it lands, so a
    // disable forces IDLE one clock after set_stb and a concurrent strobe is dropped.
    assign w_wr_ctrl     = bus.set_stb && (bus.set_addr == SR_CTRL);
    assign w_enable_next = w_wr_ctrl ? bus.set_data[0] : r_enable;

    assign w_lo_eff     = (r_thresh_lo < r_thresh_hi) ? r_thresh_lo : r_thresh_hi;
    assign w_above      = bus.power_in >= r_thresh_hi;
    assign w_below      = bus.power_in < w_lo_eff;
    assign w_dwell_eff  = (r_dwell == 8'd0) ? 8'd1 : r_dwell;
    assign w_dwell_inc  = {1'b0, r_dwell_cnt} + 9'd1;
    // >= rather than == so lowering dwell while arming cannot strand the count
    assign w_dwell_done = w_dwell_inc >= {1'b0, w_dwell_eff};
    assign w_peak_max   = (bus.power_in > r_peak) ? bus.power_in : r_peak;

    always_comb begin
        w_state_next     = r_state;
        w_dwell_cnt_next = r_dwell_cnt;
        w_hold_cnt_next  = r_hold_cnt;
        w_peak_next      = r_peak;
        w_peak_out_next  = r_peak_out;
        w_trigger_next   = 1'b0;
        w_peak_stb_next  = 1'b0;

        if (!w_enable_next) begin
            w_state_next     = S_IDLE;
            w_dwell_cnt_next = 8'd0;
            w_hold_cnt_next  = 16'd0;
            w_peak_next      = 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_BELOW;
                end
                S_BELOW: begin
                    if (bus.strobe_in && w_above) begin
                        if (w_dwell_eff == 8'd1) begin
                            w_state_next     = S_ACTIVE;
                            w_dwell_cnt_next = 8'd0;
                            w_trigger_next   = 1'b1;
                            w_peak_next      = bus.power_in;
                        end else begin
                            w_state_next     = S_ARMING;
                            w_dwell_cnt_next = 8'd1;
                        end
                    end
                end
                S_ARMING: begin
                    if (bus.strobe_in) begin
                        if (!w_above) begin
                            w_state_next     = S_BELOW;
                            w_dwell_cnt_next = 8'd0;
                        end else if (w_dwell_done) begin
                            w_state_next     = S_ACTIVE;
                            w_dwell_cnt_next = 8'd0;
                            w_trigger_next   = 1'b1;
                            w_peak_next      = bus.power_in;
                        end else begin
                            w_dwell_cnt_next = w_dwell_inc[7:0];
                        end
                    end
                end
                S_ACTIVE: begin
                    if (bus.strobe_in) begin
                        w_peak_next = w_peak_max;
                        if (w_below) begin
                            w_peak_out_next = w_peak_max;
                            w_peak_stb_next = 1'b1;
                            if (r_holdoff == 16'd0) begin
                                w_state_next = S_BELOW;
                            end else begin
                                w_state_next    = S_HOLDOFF;
                                w_hold_cnt_next = r_holdoff;
                            end
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (bus.strobe_in) begin
                        if (r_hold_cnt <= 16'd1) begin
                            w_state_next    = S_BELOW;
                            w_hold_cnt_next = 16'd0;
                        end else begin
                            w_hold_cnt_next = r_hold_cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dwell_cnt <= 8'd0;
            r_hold_cnt  <= 16'd0;
            r_peak      <= 32'd0;
            r_peak_out  <= 32'd0;
            r_trigger   <= 1'b0;
            r_peak_stb  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dwell_cnt <= w_dwell_cnt_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_peak      <= w_peak_next;
            r_peak_out  <= w_peak_out_next;
            r_trigger   <= w_trigger_next;
            r_peak_stb  <= w_peak_stb_next;
        end
    end

`ifdef POWER_THRESH_EVENT_COUNT_EN
    logic [15:0] r_event_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_count <= 16'd0;
        end else if (w_enable_next && !r_enable) begin
            r_event_count <= 16'd0;
        end else if (w_trigger_next && (r_event_count != 16'hFFFF)) begin
            r_event_count <= r_event_count + 16'd1;
        end
    end

    assign bus.event_count = r_event_count;
`else
    assign bus.event_count = 16'h0;
`endif

    assign bus.trigger_out = r_trigger;
    assign bus.active      = (r_state == S_ACTIVE);
    assign bus.peak_out    = r_peak_out;
    assign bus.peak_strobe = r_peak_stb;

endmodule

// File: doc/power_threshold_detect.md
Name: power_threshold_detect

Overview:
Sits directly downstream of the power integrator and consumes its 32-bit unsigned integrated-power stream (power_in/strobe_in). Compares each power sample against programmable high/low thresholds with hysteresis, a minimum-dwell qualifier and a post-event holdoff. Emits a one-cycle trigger pulse, an "active" level, and the peak power of each completed event. Configured over the standard 8-bit-address/32-bit-data settings bus.

Parameters:
SR_THRESH_HI, 0, settings address of the high (assert) threshold, 32 bits
SR_THRESH_LO, 1, settings address of the low (release) threshold, 32 bits
SR_CTRL, 2, settings address of control: bit0 enable, bits[15:8] dwell count (N consecutive samples)
SR_HOLDOFF, 3, settings address of holdoff length in input samples, 16 bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
power_in  in  32  unsigned integrated power sample
strobe_in  in  1  power_in valid, single-cycle qualifier
trigger_out  out  1  one-cycle pulse at event start
active  out  1  high from event start until release
peak_out  out  32  maximum power_in seen during the last completed event
peak_strobe  out  1  one-cycle pulse, peak_out valid
event_count  out  16  events detected since enable (optional feature, else 0)

Behaviour:
- Clock and reset: clk, single domain; reset synchronous active-high. All settings registers reset to 0. Block is disabled after reset.
- Reset values: trigger_out=0, active=0, peak_out=0, peak_strobe=0, event_count=0, state=IDLE.
- State advances only on cycles with strobe_in=1, except for disable/reset.
- Definitions:
  - above = power_in >= thresh_hi.
  - below = power_in < lo_eff, where lo_eff = min(thresh_lo, thresh_hi). Clamping guarantees hysteresis never inverts.
  - Effective dwell = max(dwell, 1).
- States:
  - IDLE: enable=0. Go to BELOW when enable=1.
  - BELOW: on strobe with above, dwell_cnt<=1. If effective dwell==1, go directly to ACTIVE; else go to ARMING.
  - ARMING:
    - On strobe with above: dwell_cnt++. On reaching effective dwell, go to ACTIVE.
    - On strobe not above: go back to BELOW, dwell_cnt<=0.
  - ACTIVE:
    - Entry: trigger_out pulses for exactly one cycle, registered on the cycle after the qualifying strobe. active=1 from that same cycle. peak register <= the qualifying power_in.
    - Each strobe: peak <= max(peak, power_in).
    - On strobe with below: active<=0, peak_out<=peak, peak_strobe pulses one cycle (next cycle). If holdoff=0 go to BELOW, else go to HOLDOFF with hold_cnt<=holdoff.
    - Samples between lo_eff and thresh_hi keep ACTIVE.
  - HOLDOFF:
    - Each strobe: hold_cnt--. Go to BELOW when hold_cnt reaches 0.
    - Samples are ignored for detection. The sample that takes hold_cnt to 0 is not evaluated.
- Latency: trigger_out, active and peak_strobe all change exactly 1 clk after the deciding strobe_in.
- Disable mid-operation: from any state go to IDLE on the next clk. active is forced to 0; no peak_strobe or trigger is generated; dwell, hold and peak counters are cleared. peak_out retains its last reported value.
- Settings writes: take effect on the clk after set_stb. A threshold change during ACTIVE applies to the next strobe. A holdoff change during HOLDOFF does not reload hold_cnt.
- Simultaneous enable write and strobe_in: the strobe is ignored.
- Back-to-back strobes (every cycle) are fully supported.

Optional Feature:
Macro: POWER_THRESH_EVENT_COUNT_EN.
- Defined: event_count is a 16-bit counter.
  - Increments on every trigger_out pulse and saturates at 16'hFFFF.
  - Cleared by reset and on the enable 0->1 transition.
- Undefined: event_count is tied to 16'h0 and no counter logic is built.

Test Plan:
1. Threshold hi=1000, lo=500, dwell=1, holdoff=0, enable. Stream 100,1200,800,1500,400 -> trigger_out pulses 1 clk after the 1200 strobe; active stays high through 800 and 1500; after 400, peak_out=1500 with peak_strobe=1 and active=0.
2. Dwell=3, hi=1000. Stream 1100,1100,900,1100,1100,1100 -> no trigger on the first pair; trigger 1 clk after the 6th strobe.
3. Holdoff=2, hi=1000, lo=500. Event ends on sample 400; next samples 2000,2000,2000 -> first two ignored; third re-arms from BELOW and triggers (dwell=1).
4. thresh_lo=2000, thresh_hi=1000 (inverted) -> lo_eff=1000. Stream 1500,1200,999 -> trigger at 1500; release only at 999 with peak_out=1500.
5. Drive ACTIVE, then write enable=0 -> active=0 next clk, no peak_strobe; re-enable and send 1200 -> fresh trigger; with POWER_THRESH_EVENT_COUNT_EN, event_count=1 after re-enable.
6. reset asserted while ACTIVE with strobes continuing -> all outputs 0 the next clk; remains in IDLE until enable is written.
